// File: rtl/unified_buffer_banked.sv
// rtl/unified_buffer_banked.sv - lane-masked wide buffer with credit-gated burst read engine
module ub_out_fifo #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic [1:0]   count
);
    logic [W-1:0] skid_q;
    logic         skid_valid_q;

    // The head register only changes when it is empty or being popped,
    // so the presented beat is stable under backpressure.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else if (!out_valid || pop) begin
            if (skid_valid_q) begin
                out_data     <= skid_q;
                out_valid    <= 1'b1;
                skid_valid_q <= push;
                if (push) begin
                    skid_q <= push_data;
                end
            end else begin
                out_valid <= push;
                if (push) begin
                    out_data <= push_data;
                end
            end
        end else if (push) begin
            skid_q       <= push_data;
            skid_valid_q <= 1'b1;
        end
    end

    assign count = {1'b0, out_valid} + {1'b0, skid_valid_q};
endmodule

module unified_buffer_banked #(
    parameter int LANES  = 32,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [LANES-1:0]  wr_mask_i,
    input  logic [DATA_W-1:0] wr_data_i [LANES],
    input  logic              burst_start_i,
    input  logic [ADDR_W-1:0] burst_addr_i,
    input  logic [LEN_W-1:0]  burst_len_i,
    output logic              burst_busy_o,
    output logic              burst_done_o,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic [DATA_W-1:0] rd_data_o [LANES],
    output logic              rd_last_o,
    output logic              err_o
);
    localparam int FW = LANES * DATA_W + 1;

    typedef logic [LANES-1:0][DATA_W-1:0] word_t;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    word_t             mem [DEPTH];
    word_t             ram_q;
    word_t             out_word;
    logic              ram_vld_q, ram_last_q;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              done_q, done_d, err_q, err_d;
    logic              issue, issue_last, credit, pop;
    logic [1:0]        fifo_count;
    logic [2:0]        occ_sum;
    logic [FW-1:0]     fifo_out;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_mask_i[i]) begin
                    mem[wr_addr_i][i] <= wr_data_i[i];
                end
            end
        end
    end

    // Non-blocking read alongside the write gives read-first collisions.
    always_ff @(posedge clk_i) begin
        if (issue) begin
            ram_q <= mem[addr_q];
        end
    end

    assign pop     = rd_valid_o & rd_ready_i;
    assign occ_sum = {1'b0, fifo_count} + {2'b0, ram_vld_q};
    // A beat leaving this cycle frees its slot, keeping one beat per cycle.
    assign credit  = occ_sum < (3'd2 + {2'b0, pop});

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        done_d     = 1'b0;
        err_d      = err_q;
        issue      = 1'b0;
        issue_last = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (burst_start_i) begin
                    if (burst_len_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d  = burst_addr_i;
                        rem_d   = burst_len_i;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (burst_start_i) err_d = 1'b1;
                if (credit) begin
                    issue      = 1'b1;
                    issue_last = (rem_q == LEN_W'(1));
                    addr_d     = addr_q + ADDR_W'(1);
                    rem_d      = rem_q - LEN_W'(1);
                    if (issue_last) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (burst_start_i) err_d = 1'b1;
                if (pop && rd_last_o) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ram_vld_q  <= 1'b0;
            ram_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            done_q     <= done_d;
            err_q      <= err_d;
            ram_vld_q  <= issue;
            ram_last_q <= issue_last;
        end
    end

    ub_out_fifo #(.W(FW)) u_out_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push     (ram_vld_q),
        .push_data({ram_last_q, ram_q}),
        .pop      (pop),
        .out_valid(rd_valid_o),
        .out_data (fifo_out),
        .count    (fifo_count)
    );

    assign rd_last_o = fifo_out[FW-1];
    assign out_word  = fifo_out[FW-2:0];

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            rd_data_o[i] = out_word[i];
        end
    end

    assign burst_busy_o = (state_q != S_IDLE);
    assign burst_done_o = done_q;
    assign err_o        = err_q;
endmodule

// File: tb/tb_unified_buffer_banked.sv
// tb/tb_unified_buffer_banked.sv - directed and randomized bursts against an array/queue model
module tb_unified_buffer_banked;
    localparam int LANES = 4;
    localparam int DATA_W = 16;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [3:0]  wr_mask;
    logic [15:0] wr_data [LANES];
    logic        burst_start;
    logic [3:0]  burst_addr;
    logic [4:0]  burst_len;
    logic        busy, done, rd_valid, rd_ready, rd_last, err;
    logic [15:0] rd_data [LANES];
    logic [63:0] rd_pack;

    logic [15:0] mem_m [DEPTH][LANES];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    unified_buffer_banked #(.LANES(LANES), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_mask_i(wr_mask), .wr_data_i(wr_data),
        .burst_start_i(burst_start), .burst_addr_i(burst_addr), .burst_len_i(burst_len),
        .burst_busy_o(busy), .burst_done_o(done),
        .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data),
        .rd_last_o(rd_last), .err_o(err)
    );

    always_comb begin
        rd_pack = '0;
        for (int i = 0; i < LANES; i++) rd_pack[16*i +: 16] = rd_data[i];
    end

    function automatic logic [63:0] mword(input int a);
        logic [63:0] w;
        for (int i = 0; i < LANES; i++) w[16*i +: 16] = mem_m[a][i];
        return w;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input int a, input logic [3:0] m, input logic [63:0] d);
        @(negedge clk);
        wr_en = 1'b1;
        wr_addr = 4'(a);
        wr_mask = m;
        for (int i = 0; i < LANES; i++) begin
            wr_data[i] = d[16*i +: 16];
            if (m[i]) mem_m[a][i] = d[16*i +: 16];
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // mode: 0 ready always, 1 ready pattern 1,0,0,1,0,1 repeating, 2 random ready.
    // wr_cyc >= 0 writes wr_word to addr a on edge E(wr_cyc+1); err_cyc pulses a stray start.
    task automatic run_burst(input int a, input int len, input int mode,
                             input int wr_cyc, input logic [63:0] wr_word, input int err_cyc);
        logic [63:0] exp_q [$];
        logic [63:0] held_data;
        logic        held_last, stalled, r;
        logic [5:0]  pat;
        int beats, cyc, first_valid, last_cyc, done_cyc, dones;
        pat = 6'b101001;
        for (int i = 0; i < len; i++) exp_q.push_back(mword((a + i) % DEPTH));
        beats = 0; first_valid = -1; last_cyc = -1; done_cyc = -1; dones = 0;
        stalled = 1'b0; held_data = '0; held_last = 1'b0;
        @(negedge clk);
        burst_start = 1'b1; burst_addr = 4'(a); burst_len = 5'(len); rd_ready = 1'b1;
        @(negedge clk);
        burst_start = 1'b0;
        cyc = 0;
        while (cyc < 300 && (done_cyc < 0 || cyc <= done_cyc + 2)) begin
            if (rd_valid && first_valid < 0) first_valid = cyc;
            if (done) begin
                dones++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    chk("busy_at_done", {63'd0, busy}, 64'd0);
                end
            end
            if (len == 0) chk("len0_busy", {63'd0, busy}, 64'd0);
            if (stalled) begin
                chk("stall_valid", {63'd0, rd_valid}, 64'd1);
                chk("stall_data", rd_pack, held_data);
                chk("stall_last", {63'd0, rd_last}, {63'd0, held_last});
            end
            if (cyc == wr_cyc) begin
                wr_en = 1'b1; wr_addr = 4'(a); wr_mask = 4'hF;
                for (int i = 0; i < LANES; i++) wr_data[i] = wr_word[16*i +: 16];
            end else begin
                wr_en = 1'b0;
            end
            burst_start = (cyc == err_cyc);
            if (cyc == err_cyc) begin
                burst_addr = 4'd9; burst_len = 5'd2;
            end
            case (mode)
                0: r = 1'b1;
                1: r = pat[cyc % 6];
                default: r = 1'($urandom_range(0, 1));
            endcase
            rd_ready = r;
            if (rd_valid && r) begin
                if (beats < len) begin
                    chk("beat_data", rd_pack, exp_q[beats]);
                    chk("beat_last", {63'd0, rd_last}, {63'd0, (beats == len - 1)});
                end else begin
                    chk("extra_beat", 64'(beats), 64'(len - 1));
                end
                beats++;
                if (beats == len) last_cyc = cyc;
                stalled = 1'b0;
            end else begin
                stalled = rd_valid;
                held_data = rd_pack;
                held_last = rd_last;
            end
            @(negedge clk);
            cyc++;
        end
        burst_start = 1'b0; wr_en = 1'b0; rd_ready = 1'b1;
        if (wr_cyc >= 0)
            for (int i = 0; i < LANES; i++) mem_m[a][i] = wr_word[16*i +: 16];
        chk("beat_count", 64'(beats), 64'(len));
        chk("done_count", 64'(dones), 64'd1);
        chk("done_timing", 64'(done_cyc), (len == 0) ? 64'd0 : 64'(last_cyc + 1));
        if (len > 0) chk("first_latency", 64'(first_valid), 64'd2);
        if (mode == 0 && len > 0) chk("throughput", 64'(last_cyc), 64'(len + 1));
        chk("idle_busy", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        int beats, cyc;
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_mask = '0;
        for (int i = 0; i < LANES; i++) wr_data[i] = '0;
        burst_start = 1'b0; burst_addr = '0; burst_len = '0; rd_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_valid", {63'd0, rd_valid}, 64'd0);
        chk("rst_last", {63'd0, rd_last}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_data", rd_pack, 64'd0);
        rst_n = 1'b1;

        for (int a = 0; a < DEPTH; a++) do_write(a, 4'hF, {$urandom, $urandom});

        do_write(3, 4'hF, {16'd4, 16'd3, 16'd2, 16'd1});
        run_burst(3, 1, 0, -1, 64'd0, -1);
        do_write(3, 4'b0101, {4{16'd9}});
        run_burst(3, 1, 0, -1, 64'd0, -1);

        for (int k = 0; k < 4; k++) do_write((14 + k) % DEPTH, 4'hF, {4{16'((14 + k) % DEPTH)}});
        run_burst(14, 4, 0, -1, 64'd0, -1);

        for (int k = 0; k < 8; k++) do_write(k, 4'hF, {4{16'(k)}});
        run_burst(0, 8, 1, -1, 64'd0, -1);

        run_burst(5, 0, 0, -1, 64'd0, -1);

        do_write(5, 4'hF, {4{16'h00AA}});
        chk("err_before", {63'd0, err}, 64'd0);
        run_burst(5, 1, 0, 0, {4{16'h00BB}}, -1);
        run_burst(5, 1, 0, -1, 64'd0, -1);

        run_burst(0, 4, 0, -1, 64'd0, 1);
        chk("err_set", {63'd0, err}, 64'd1);
        run_burst(2, 3, 2, -1, 64'd0, -1);
        chk("err_sticky", {63'd0, err}, 64'd1);

        for (int t = 0; t < 25; t++) begin
            int nw;
            nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++)
                do_write($urandom_range(0, DEPTH - 1), 4'($urandom), {$urandom, $urandom});
            run_burst($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH), 2, -1, 64'd0, -1);
        end

        for (int k = 0; k < 8; k++) do_write(k, 4'hF, {$urandom, $urandom});
        @(negedge clk);
        burst_start = 1'b1; burst_addr = 4'd0; burst_len = 5'd8; rd_ready = 1'b1;
        @(negedge clk);
        burst_start = 1'b0;
        beats = 0; cyc = 0;
        while (beats < 3 && cyc < 50) begin
            @(negedge clk);
            if (rd_valid) begin
                chk("pre_rst_beat", rd_pack, mword(beats));
                beats++;
            end
            cyc++;
        end
        chk("pre_rst_beats", 64'(beats), 64'd3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", {63'd0, rd_valid}, 64'd0);
        chk("async_busy", {63'd0, busy}, 64'd0);
        chk("async_err", {63'd0, err}, 64'd0);
        chk("async_data", rd_pack, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_rst_done", {63'd0, done}, 64'd0);
            chk("post_rst_valid", {63'd0, rd_valid}, 64'd0);
        end
        run_burst(0, 2, 0, -1, 64'd0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
